// File: rtl/act_sum_acc.sv
// Activation window summer: unpacks 64-bit words of uint8 activations one byte per clock
// and emits one sum per window. Optional macro ACT_ZP_SUB_EN subtracts the activation zero point z1.
module act_sum_acc #(
  parameter int SUM_W = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len_cfg,
  input  logic [15:0]      win_cfg,
  input  logic [7:0]       z1,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  output logic             sum_valid,
  output logic [SUM_W-1:0] act_sum,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [LEN_W-1:0] r_len;
  logic [15:0]      r_win;
  logic [63:0]      r_buf;
  logic             r_full;
  logic [2:0]       r_byte_idx;
  logic [SUM_W-1:0] r_acc;
  logic [LEN_W-1:0] r_elem_cnt;
  logic [15:0]      r_win_cnt;
  logic [SUM_W-1:0] r_act_sum;
  logic             r_sum_valid;
  logic             r_done;

  logic             w_run;
  logic             w_accept;
  logic             w_consume;
  logic [7:0]       w_byte;
  logic [SUM_W-1:0] w_ext;
  logic             w_last_elem;
  logic             w_last_win;
  logic             w_start_ok;

  assign w_run       = (r_state == RUN);
  assign in_ready    = w_run && (!r_full || (r_byte_idx == 3'd7));
  assign w_accept    = in_valid && in_ready;
  assign w_consume   = w_run && r_full;
  assign w_byte      = r_buf[{r_byte_idx, 3'b000} +: 8];
  assign w_last_elem = (r_elem_cnt == (r_len - {{(LEN_W-1){1'b0}}, 1'b1}));
  assign w_last_win  = (r_win_cnt == (r_win - 16'd1));
  assign w_start_ok  = start && (len_cfg != '0) && (win_cfg != 16'd0);

`ifdef ACT_ZP_SUB_EN
  logic [7:0]        r_z1;
  logic signed [8:0] w_diff;

  // Zero-point-corrected activation lies in [-255, 255], so 9 signed bits suffice.
  assign w_diff = $signed({1'b0, w_byte}) - $signed({1'b0, r_z1});
  assign w_ext  = {{(SUM_W-9){w_diff[8]}}, w_diff};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_z1 <= 8'd0;
    end else if ((r_state == IDLE) && w_start_ok) begin
      r_z1 <= z1;
    end
  end
`else
  logic w_unused_z1;

  assign w_unused_z1 = ^z1;
  assign w_ext       = {{(SUM_W-8){1'b0}}, w_byte};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_win       <= 16'd0;
      r_buf       <= 64'd0;
      r_full      <= 1'b0;
      r_byte_idx  <= 3'd0;
      r_acc       <= '0;
      r_elem_cnt  <= '0;
      r_win_cnt   <= 16'd0;
      r_act_sum   <= '0;
      r_sum_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_sum_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_state    <= RUN;
            r_len      <= len_cfg;
            r_win      <= win_cfg;
            r_full     <= 1'b0;
            r_byte_idx <= 3'd0;
            r_acc      <= '0;
            r_elem_cnt <= '0;
            r_win_cnt  <= 16'd0;
          end
        end
        default: begin
          // A word landing while byte 7 drains refills the buffer with no bubble.
          if (w_accept) begin
            r_buf      <= in_data;
            r_full     <= 1'b1;
            r_byte_idx <= 3'd0;
          end else if (w_consume) begin
            r_byte_idx <= r_byte_idx + 3'd1;
            if (r_byte_idx == 3'd7) begin
              r_full <= 1'b0;
            end
          end

          if (w_consume) begin
            if (w_last_elem) begin
              r_act_sum   <= r_acc + w_ext;
              r_sum_valid <= 1'b1;
              r_acc       <= '0;
              r_elem_cnt  <= '0;
              r_win_cnt   <= r_win_cnt + 16'd1;
              // Final window: leftover bytes (and any word taken this cycle) are dropped.
              if (w_last_win) begin
                r_done  <= 1'b1;
                r_state <= IDLE;
                r_full  <= 1'b0;
              end
            end else begin
              r_acc      <= r_acc + w_ext;
              r_elem_cnt <= r_elem_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
            end
          end
        end
      endcase
    end
  end

  assign sum_valid = r_sum_valid;
  assign act_sum   = r_act_sum;
  assign busy      = w_run;
  assign done      = r_done;

endmodule

// File: tb/tb_act_sum_acc.sv
// Self-checking bench for act_sum_acc: randomized jobs compared against a byte-stream window-sum model.
module tb_act_sum_acc;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] len_cfg;
  logic [15:0] win_cfg;
  logic [7:0]  z1;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        sum_valid;
  logic [31:0] act_sum;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;

  logic [63:0] word_mem [0:63];
  logic [31:0] obs_sum [$];
  bit          obs_done [$];
  int          obs_cyc [$];
  int          rdy_cyc [$];
  logic [31:0] exp_sum [$];

  act_sum_acc #(.SUM_W(32), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .len_cfg(len_cfg), .win_cfg(win_cfg),
    .z1(z1), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sum_valid(sum_valid), .act_sum(act_sum), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sum_valid) begin
      obs_sum.push_back(act_sum);
      obs_done.push_back(done);
      obs_cyc.push_back(cyc);
      $display("sum: cycle=%0d act_sum=%0d (0x%08h) done=%0b", cyc, act_sum, act_sum, done);
    end
    if (done) done_cnt++;
    if (in_ready) rdy_cyc.push_back(cyc);
  end

  // Reference: flatten words into a byte stream, sum consecutive len-byte chunks.
  function automatic void build_expected(input int len, input int win, input logic [7:0] z);
    logic [63:0] wd;
    logic [7:0]  b;
    int          s;
    int          k;
    exp_sum.delete();
    for (int w = 0; w < win; w++) begin
      s = 0;
      for (int e = 0; e < len; e++) begin
        k  = w * len + e;
        wd = word_mem[k / 8];
        b  = wd[8 * (k % 8) +: 8];
`ifdef ACT_ZP_SUB_EN
        s = s + int'(b) - int'(z);
`else
        s = s + int'(b);
`endif
      end
      exp_sum.push_back(s);
    end
  endfunction

  task automatic run_job(input int len, input int win, input logic [7:0] z, input int words_n,
                         input int pct, input bit inject, output bit to);
    int widx;
    int cnt;
    int d0;
    bit acc;
    @(negedge clk);
    obs_sum.delete(); obs_done.delete(); obs_cyc.delete(); rdy_cyc.delete();
    d0 = done_cnt;
    len_cfg = len[15:0];
    win_cfg = win[15:0];
    z1 = z;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    widx = 0;
    cnt = 0;
    to = 1'b0;
    while (done_cnt == d0 && !to) begin
      if (inject && cnt == 6) begin
        start = 1'b1;
        len_cfg = len_cfg + 16'd3;
        win_cfg = 16'd7;
      end else begin
        start = 1'b0;
      end
      in_valid = (widx < words_n) && ($urandom_range(99) < pct);
      in_data = (widx < words_n) ? word_mem[widx] : 64'd0;
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) widx++;
      cnt++;
      if (cnt > 3000) to = 1'b1;
    end
    start = 1'b0;
    in_valid = 1'b0;
    $display("job: len=%0d win=%0d z1=%0d words_taken=%0d sums=%0d cycles=%0d", len, win, z, widx, obs_sum.size(), cnt);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0; len_cfg = 16'd0; win_cfg = 16'd0; z1 = 8'd0;
    in_valid = 1'b0; in_data = 64'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
    total++; if (sum_valid !== 1'b0) begin bad++; $display("FAIL reset_sum_valid got=%0b want=0", sum_valid); end
    total++; if (act_sum !== 32'd0) begin bad++; $display("FAIL reset_act_sum got=%0h want=0", act_sum); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
  endtask

  task automatic test_single_word;
    bit to;
    word_mem[0] = 64'h0807060504030201;
    run_job(8, 1, 8'd0, 1, 100, 1'b0, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL single_timeout got=%0b want=0", to); end
    total++; if (obs_sum.size() != 1) begin bad++; $display("FAIL single_count got=%0d want=1", obs_sum.size()); end
    if (obs_sum.size() > 0) begin
      total++; if (obs_sum[0] !== 32'd36) begin bad++; $display("FAIL single_sum got=%0d want=36", obs_sum[0]); end
      total++; if (obs_done[0] !== 1'b1) begin bad++; $display("FAIL single_done got=%0b want=1", obs_done[0]); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%0b want=0", busy); end
  endtask

  task automatic test_boundary;
    bit to;
    for (int i = 0; i < 3; i++) word_mem[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_job(9, 2, 8'd0, 3, 100, 1'b0, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL boundary_timeout got=%0b want=0", to); end
    total++; if (obs_sum.size() != 2) begin bad++; $display("FAIL boundary_count got=%0d want=2", obs_sum.size()); end
    for (int i = 0; i < obs_sum.size() && i < 2; i++) begin
      total++; if (obs_sum[i] !== 32'd2295) begin bad++; $display("FAIL boundary_sum%0d got=%0d want=2295", i, obs_sum[i]); end
      total++; if (obs_done[i] !== (i == 1)) begin bad++; $display("FAIL boundary_done%0d got=%0b want=%0b", i, obs_done[i], i == 1); end
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL boundary_in_ready got=%0b want=0", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL boundary_busy got=%0b want=0", busy); end
  endtask

  task automatic test_back_to_back;
    bit to;
    for (int i = 0; i < 2; i++) word_mem[i] = {$urandom, $urandom};
    build_expected(4, 4, 8'd0);
    run_job(4, 4, 8'd0, 2, 100, 1'b0, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL b2b_timeout got=%0b want=0", to); end
    total++; if (obs_sum.size() != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", obs_sum.size()); end
    for (int i = 0; i < obs_sum.size() && i < 4; i++) begin
      total++; if (obs_sum[i] !== exp_sum[i]) begin bad++; $display("FAIL b2b_sum%0d got=%0d want=%0d", i, obs_sum[i], exp_sum[i]); end
      if (i > 0) begin
        total++; if (obs_cyc[i] - obs_cyc[i-1] != 4) begin bad++; $display("FAIL b2b_spacing%0d got=%0d want=4", i, obs_cyc[i] - obs_cyc[i-1]); end
      end
    end
    total++; if (rdy_cyc.size() != 3) begin bad++; $display("FAIL b2b_ready_count got=%0d want=3", rdy_cyc.size()); end
    for (int i = 1; i < rdy_cyc.size(); i++) begin
      total++; if (rdy_cyc[i] - rdy_cyc[i-1] != 8) begin bad++; $display("FAIL b2b_ready_gap%0d got=%0d want=8", i, rdy_cyc[i] - rdy_cyc[i-1]); end
    end
  endtask

  task automatic test_random;
    bit to;
    int len, win, words, pct;
    logic [7:0] z;
    for (int j = 0; j < 8; j++) begin
      len = $urandom_range(1, 20);
      win = $urandom_range(1, 5);
      pct = $urandom_range(30, 100);
      z = 8'($urandom_range(0, 255));
      words = (len * win + 7) / 8;
      for (int i = 0; i < words; i++) word_mem[i] = {$urandom, $urandom};
      build_expected(len, win, z);
      run_job(len, win, z, words, pct, 1'b0, to);
      total++; if (to !== 1'b0) begin bad++; $display("FAIL rand%0d_timeout got=%0b want=0", j, to); end
      total++; if (obs_sum.size() != win) begin bad++; $display("FAIL rand%0d_count got=%0d want=%0d", j, obs_sum.size(), win); end
      for (int i = 0; i < obs_sum.size() && i < win; i++) begin
        total++; if (obs_sum[i] !== exp_sum[i]) begin bad++; $display("FAIL rand%0d_sum%0d got=%0d want=%0d", j, i, obs_sum[i], exp_sum[i]); end
        total++; if (obs_done[i] !== (i == win - 1)) begin bad++; $display("FAIL rand%0d_done%0d got=%0b want=%0b", j, i, obs_done[i], i == win - 1); end
      end
    end
  endtask

  task automatic test_illegal_start;
    bit to;
    @(negedge clk);
    len_cfg = 16'd0; win_cfg = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL illegal_len0_busy got=%0b want=0", busy); end
    len_cfg = 16'd5; win_cfg = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL illegal_win0_busy got=%0b want=0", busy); end
    for (int i = 0; i < 3; i++) word_mem[i] = {$urandom, $urandom};
    build_expected(9, 2, 8'd0);
    run_job(9, 2, 8'd0, 3, 100, 1'b1, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL busy_start_timeout got=%0b want=0", to); end
    total++; if (obs_sum.size() != 2) begin bad++; $display("FAIL busy_start_count got=%0d want=2", obs_sum.size()); end
    for (int i = 0; i < obs_sum.size() && i < 2; i++) begin
      total++; if (obs_sum[i] !== exp_sum[i]) begin bad++; $display("FAIL busy_start_sum%0d got=%0d want=%0d", i, obs_sum[i], exp_sum[i]); end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_idle got=%0b want=0", busy); end
  endtask

  task automatic test_reset_mid;
    bit to;
    @(negedge clk);
    len_cfg = 16'd9; win_cfg = 16'd1; z1 = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = {$urandom, $urandom};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    obs_sum.delete();
    #2 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%0b want=0", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midreset_in_ready got=%0b want=0", in_ready); end
    total++; if (sum_valid !== 1'b0) begin bad++; $display("FAIL midreset_sum_valid got=%0b want=0", sum_valid); end
    total++; if (act_sum !== 32'd0) begin bad++; $display("FAIL midreset_act_sum got=%0h want=0", act_sum); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midreset_done got=%0b want=0", done); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (obs_sum.size() != 0) begin bad++; $display("FAIL midreset_partial_sum got=%0d want=0", obs_sum.size()); end
    for (int i = 0; i < 2; i++) word_mem[i] = {$urandom, $urandom};
    build_expected(9, 1, 8'd0);
    run_job(9, 1, 8'd0, 2, 70, 1'b0, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL midreset_job_timeout got=%0b want=0", to); end
    total++; if (obs_sum.size() != 1) begin bad++; $display("FAIL midreset_job_count got=%0d want=1", obs_sum.size()); end
    if (obs_sum.size() > 0) begin
      total++; if (obs_sum[0] !== exp_sum[0]) begin bad++; $display("FAIL midreset_job_sum got=%0d want=%0d", obs_sum[0], exp_sum[0]); end
    end
  endtask

  task automatic test_zero_point;
    bit to;
    logic [31:0] want;
    word_mem[0] = 64'h0000_0000_0000_FF00;
`ifdef ACT_ZP_SUB_EN
    want = 32'hFFFF_FFFF;
`else
    want = 32'd255;
`endif
    run_job(2, 1, 8'd128, 1, 100, 1'b0, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL zp_timeout got=%0b want=0", to); end
    total++; if (obs_sum.size() != 1) begin bad++; $display("FAIL zp_count got=%0d want=1", obs_sum.size()); end
    if (obs_sum.size() > 0) begin
      total++; if (obs_sum[0] !== want) begin bad++; $display("FAIL zp_sum got=%08h want=%08h", obs_sum[0], want); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_boundary();
    test_back_to_back();
    test_random();
    test_illegal_start();
    test_reset_mid();
    test_zero_point();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
